// File: rtl/shift_right_seq_pkg.sv
// Shared MIPS definitions for the sequential right-shifter: opcode/funct
// encodings, counter width and the FSM state type.
package shift_right_seq_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_right_decode.sv
// Combinational decode of opcode/funct into shift kind and shift amount.
// Anything that is not one of the four right shifts is a zero-length pass-through.
module shift_right_decode
  import shift_right_seq_pkg::*;
(
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic [4:0]       rs_amt,
  output logic             is_right,
  output logic             is_arith,
  output logic [CNT_W-1:0] amt
);

  // Classify the instruction and select immediate or register amount
  always_comb begin
    is_right = 1'b0;
    is_arith = 1'b0;
    amt      = 5'd0;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FUNCT_SRL: begin
          is_right = 1'b1;
          amt      = shamt;
        end
        FUNCT_SRA: begin
          is_right = 1'b1;
          is_arith = 1'b1;
          amt      = shamt;
        end
        FUNCT_SRLV: begin
          is_right = 1'b1;
          amt      = rs_amt;
        end
        FUNCT_SRAV: begin
          is_right = 1'b1;
          is_arith = 1'b1;
          amt      = rs_amt;
        end
        default: begin
          is_right = 1'b0;
          is_arith = 1'b0;
          amt      = 5'd0;
        end
      endcase
    end else begin
      is_right = 1'b0;
      is_arith = 1'b0;
      amt      = 5'd0;
    end
  end

endmodule

// File: rtl/shift_right_seq.sv
// Sequential MIPS right shifter (SRL/SRA/SRLV/SRAV), one bit per clock.
// data_out mirrors the work register; it is only meaningful while done is high.
module shift_right_seq
  import shift_right_seq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  input  logic [4:0]   shamt,
  input  logic [4:0]   rs_amt,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  output logic         busy,
  output logic         done
);

  state_e             state_r;
  state_e             state_s;
  logic [W-1:0]       work_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               arith_r;
  logic               busy_r;
  logic               done_r;

  logic               is_right_s;
  logic               is_arith_s;
  logic [CNT_W-1:0]   amt_s;
  logic [CNT_W-1:0]   load_amt_s;
  logic               accept_s;

  shift_right_decode u_decode (
    .opcode   (opcode),
    .funct    (funct),
    .shamt    (shamt),
    .rs_amt   (rs_amt),
    .is_right (is_right_s),
    .is_arith (is_arith_s),
    .amt      (amt_s)
  );

  // Acceptance window and the amount actually loaded into the counter
  always_comb begin
    accept_s   = 1'b0;
    load_amt_s = 5'd0;
    if (start && ((state_r == IDLE) || (state_r == DONE))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (is_right_s) begin
      load_amt_s = amt_s;
    end else begin
      load_amt_s = 5'd0;
    end
  end

  // Next-state logic; DONE can chain straight into a new operation
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          if (load_amt_s == 5'd0) begin
            state_s = DONE;
          end else begin
            state_s = SHIFT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == 5'd1) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      work_r  <= '0;
      cnt_r   <= 5'd0;
      arith_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == SHIFT);
      done_r  <= (state_s == DONE);
      if (accept_s) begin
        work_r  <= data_in;
        cnt_r   <= load_amt_s;
        arith_r <= is_arith_s;
      end else if (state_r == SHIFT) begin
        // Arithmetic shifts keep re-inserting the sign bit held in bit W-1
        work_r <= {arith_r & work_r[W-1], work_r[W-1:1]};
        cnt_r  <= cnt_r - 5'd1;
      end else begin
        work_r <= work_r;
        cnt_r  <= cnt_r;
      end
    end
  end

  assign data_out = work_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq: table of single operations plus
// hand-written back-to-back, mid-shift start and mid-shift reset sequences.
module tb_shift_right_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [4:0]  rs_amt;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  int total;
  int bad;
  logic [31:0] sb_q[$];

  typedef struct {
    string       name;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rs_amt;
    logic [31:0] din;
    logic [31:0] dexp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  shift_right_seq #(.W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .opcode   (opcode),
    .funct    (funct),
    .shamt    (shamt),
    .rs_amt   (rs_amt),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [4:0] rs, input logic [31:0] din);
    opcode  = op;
    funct   = fn;
    shamt   = sh;
    rs_amt  = rs;
    data_in = din;
  endtask

  // Called just after the accepting edge; counts busy cycles until done
  task automatic wait_done(input string name, input int exp_lat, input int poke);
    int cycles;
    int busy_cnt;
    bit seen;
    logic [31:0] exp_d;
    cycles = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && cycles < 40) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        if (poke >= 0 && cycles == poke) begin
          start = 1'b1;
          drive(6'h00, 6'h03, 5'd3, 5'd9, 32'h8000_0000);
        end else if (poke >= 0 && cycles == poke + 1) begin
          start = 1'b0;
        end
        cycles++;
      end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_latency"}, 32'(cycles), 32'(exp_lat));
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    if (seen) begin
      if (sb_q.size() == 0) begin
        check({name, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
        exp_d = sb_q.pop_front();
        check({name, "_data"}, data_out, exp_d);
      end
    end else begin
      sb_q.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v.opcode, v.funct, v.shamt, v.rs_amt, v.din);
    start = 1'b1;
    sb_q.push_back(v.dexp);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(v.name, v.lat, -1);
    @(negedge clk);
    check({v.name, "_pulse_end"}, 32'(done), 32'd0);
    check({v.name, "_hold"}, data_out, v.dexp);
  endtask

  initial begin
    bit seen;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    drive(6'h00, 6'h00, 5'd0, 5'd0, 32'h0);

    vecs[0]  = '{"srl31",     6'h00, 6'h02, 5'd31, 5'd0,  32'h8000_0000, 32'h0000_0001, 31};
    vecs[1]  = '{"sra4",      6'h00, 6'h03, 5'd4,  5'd0,  32'h8000_0000, 32'hF800_0000, 4};
    vecs[2]  = '{"srav4",     6'h00, 6'h07, 5'd9,  5'd4,  32'h8000_0000, 32'hF800_0000, 4};
    vecs[3]  = '{"srlv0",     6'h00, 6'h06, 5'd5,  5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0};
    vecs[4]  = '{"lw_pass",   6'h23, 6'h02, 5'd7,  5'd3,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0};
    vecs[5]  = '{"srl8",      6'h00, 6'h02, 5'd8,  5'd3,  32'h1234_5678, 32'h0012_3456, 8};
    vecs[6]  = '{"sra_pos",   6'h00, 6'h03, 5'd4,  5'd0,  32'h7FFF_FFF0, 32'h07FF_FFFF, 4};
    vecs[7]  = '{"srav31",    6'h00, 6'h07, 5'd0,  5'd31, 32'h8000_0001, 32'hFFFF_FFFF, 31};
    vecs[8]  = '{"srlv28",    6'h00, 6'h06, 5'd2,  5'd28, 32'hF000_0000, 32'h0000_000F, 28};
    vecs[9]  = '{"add_pass",  6'h00, 6'h20, 5'd6,  5'd6,  32'hCAFE_F00D, 32'hCAFE_F00D, 0};
    vecs[10] = '{"sra0",      6'h00, 6'h03, 5'd0,  5'd7,  32'h8000_0000, 32'h8000_0000, 0};
    vecs[11] = '{"srl1",      6'h00, 6'h02, 5'd1,  5'd0,  32'h0000_0003, 32'h0000_0001, 1};

    #3;
    check("reset_data", data_out, 32'h0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i]);
    end

    // Back-to-back: start held through DONE, second op accepted with no bubble
    @(negedge clk);
    drive(6'h00, 6'h02, 5'd2, 5'd0, 32'h0000_0008);
    start = 1'b1;
    sb_q.push_back(32'h0000_0002);
    @(posedge clk);
    #1 drive(6'h00, 6'h02, 5'd1, 5'd0, 32'h0000_0002);
    sb_q.push_back(32'h0000_0001);
    wait_done("b2b_first", 2, -1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("b2b_second", 1, -1);
    @(negedge clk);
    check("b2b_pulse_end", 32'(done), 32'd0);

    // start pulsed mid-shift with different operands must be ignored
    @(negedge clk);
    drive(6'h00, 6'h02, 5'd6, 5'd0, 32'h0000_FF00);
    start = 1'b1;
    sb_q.push_back(32'h0000_03FC);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("midstart", 6, 2);
    @(negedge clk);
    check("midstart_pulse_end", 32'(done), 32'd0);

    // Reset in the middle of a 10-bit shift aborts it without a done pulse
    @(negedge clk);
    drive(6'h00, 6'h02, 5'd10, 5'd0, 32'hFFFF_0000);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_data", data_out, 32'h0);
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_done", 32'(done), 32'd0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    run_vec('{"post_reset_srl2", 6'h00, 6'h02, 5'd2, 5'd0, 32'h0000_0010, 32'h0000_0004, 2});

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_right_seq.md
SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 Parameter W, default 32, datapath width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only when state is IDLE or DONE.
REQ-005 opcode  input  6  instruction opcode.
REQ-006 funct  input  6  instruction function field.
REQ-007 shamt  input  5  immediate shift amount (SRL, SRA).
REQ-008 rs_amt  input  5  register shift amount, rs[4:0] (SRLV, SRAV).
REQ-009 data_in  input  W  operand (rt value).
REQ-010 data_out  output  W  result register; holds the last result until the next accepted start.
REQ-011 busy  output  1  high while state is SHIFT.
REQ-012 done  output  1  one-cycle pulse; data_out is valid while done is high.

Function
REQ-013 Decode shall treat opcode 6'h0 with funct 6'h02 as SRL, 6'h03 as SRA, 6'h06 as SRLV and 6'h07 as SRAV; every other opcode/funct pair is pass-through.
REQ-014 Shift amount N shall be shamt for SRL/SRA, rs_amt for SRLV/SRAV, and 0 for pass-through.
REQ-015 FSM shall have exactly three states: IDLE, SHIFT and DONE.
REQ-016 On the accepting edge k: load the work register with data_in, the counter with N, and latch the arithmetic flag (SRA/SRAV).
REQ-017 On that edge, the next state shall be DONE if N==0, else SHIFT.
REQ-018 In SHIFT, each edge shall shift the register right by 1 and decrement the counter.
  - Logical ops fill with 0.
  - Arithmetic ops replicate the latched bit W-1.
  - On the edge where the counter goes 1->0, the next state is DONE.
REQ-019 done shall go high in the cycle after edge k+N: latency N cycles, 0..31.
REQ-020 DONE shall return to IDLE on the next edge unless start is high, in which case a new operation is accepted (back-to-back, no bubble).
REQ-021 start shall be ignored while in SHIFT; operands are not re-sampled.
REQ-022 data_out shall equal the work register, so intermediate values may be visible while busy; consumers use data_out only when done is high.
REQ-023 A pass-through operation shall return data_in unchanged with N=0, i.e. done in the cycle after the accepting edge.
REQ-024 Counter width shall be 5 bits; N=31 shall shift out all but bit W-1, with no wrap-around.

Reset
REQ-025 rst_n low shall immediately force state=IDLE, counter=0, data_out=0, busy=0, done=0, arithmetic flag=0.
REQ-026 Reset during SHIFT shall abort the operation with no done pulse; the first start after release is accepted normally.

Structure
REQ-027 Funct codes (SRL, SRA, SRLV, SRAV), the R-type opcode and the state encodings shall live in the shared MIPS definitions package/header.
REQ-028 Decode (REQ-013/014) shall be one combinational sub-module, shift_right_decode, outputting is_right, is_arith and amt[4:0].
REQ-029 Total RTL shall be 120-400 lines; no multiplier or barrel-shifter logic (one bit per cycle).

Verification
REQ-030 SRL, data_in=32'h8000_0000, shamt=31 -> busy for 31 cycles, then done with data_out=32'h0000_0001.
REQ-031 SRA, data_in=32'h8000_0000, shamt=4 -> done after 4 cycles with data_out=32'hF800_0000; SRAV with rs_amt=4 gives the identical result.
REQ-032 SRLV, rs_amt=0, data_in=32'hDEAD_BEEF; and opcode=6'h23 (LW) with any funct -> done the cycle after accept with data_out=32'hDEAD_BEEF, busy never high.
REQ-033 Back-to-back: start held through DONE with a second SRL shamt=1 on 32'h0000_0002 -> second done exactly 1 cycle after the first DONE cycle, data_out=32'h0000_0001.
REQ-034 start pulsed mid-SHIFT with different operands -> ignored; result matches the first operation.
REQ-035 rst_n asserted at cycle 3 of a shamt=10 SRL -> outputs zero asynchronously, no done; a new SRL shamt=2 on 32'h0000_0010 then yields 32'h0000_0004.
